// File: rtl/gigatron_gt1_pkg.sv
// Shared types and GT1 file-format constants for the Gigatron GT1 loader.
package gigatron_gt1_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SEG_HI,
        SEG_LO,
        SEG_SIZE,
        DATA,
        WRITE,
        EXEC_HI,
        EXEC_LO,
        DONE,
        ERROR
    } gt1_state_t;

    localparam logic [7:0] END_HI          = 8'h00;
    localparam int         SIZE_ZERO_MEANS = 256;

    // A size byte of zero encodes a full 256-byte segment.
    function automatic logic [8:0] size_decode(input logic [7:0] b);
        return (b == 8'h00) ? 9'(SIZE_ZERO_MEANS) : {1'b0, b};
    endfunction

endpackage

// File: rtl/gigatron_gt1_loader.sv
// Streams a GT1 image from an external option ROM into Gigatron RAM while holding the CPU.
// Define GT1_LOADER_BOUNDS_EN to flag reads past ROM_DEPTH as an error instead of wrapping.
module gigatron_gt1_loader
    import gigatron_gt1_pkg::*;
#(
    parameter int ROM_DEPTH  = 32768,
    parameter int RAM_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [15:0]           rom_addr,
    input  logic [7:0]            rom_data,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    input  logic                  ram_ready,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           exec_addr
);

    gt1_state_t            r_state;
    logic [15:0]           r_rom_addr;
    logic [7:0]            r_seg_hi;
    logic [7:0]            r_seg_lo;
    logic [8:0]            r_remain;
    logic                  r_first;
    logic [RAM_ADDR_W-1:0] r_ram_addr;
    logic [7:0]            r_ram_wdata;
    logic                  r_ram_we;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_error;
    logic [15:0]           r_exec_addr;

    logic                  w_reads_rom;
    logic                  w_oob;

    assign w_reads_rom = (r_state == SEG_HI)  || (r_state == SEG_LO)  ||
                         (r_state == SEG_SIZE) || (r_state == DATA)   ||
                         (r_state == EXEC_LO) || (r_state == EXEC_HI);

`ifdef GT1_LOADER_BOUNDS_EN
    assign w_oob = ({16'd0, r_rom_addr} >= 32'(ROM_DEPTH));
`else
    assign w_oob = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rom_addr  <= '0;
            r_seg_hi    <= '0;
            r_seg_lo    <= '0;
            r_remain    <= '0;
            r_first     <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_exec_addr <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_reads_rom && w_oob) begin
                r_state    <= ERROR;
                r_error    <= 1'b1;
                r_cpu_hold <= 1'b0;
                r_ram_we   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, ERROR: begin
                        if (start) begin
                            r_state    <= SEG_HI;
                            r_rom_addr <= '0;
                            r_error    <= 1'b0;
                            r_cpu_hold <= 1'b1;
                            r_first    <= 1'b1;
                        end
                    end
                    SEG_HI: begin
                        r_rom_addr <= r_rom_addr + 16'd1;
                        // The first segment may legitimately start in page zero.
                        if (rom_data == END_HI && !r_first) begin
                            r_state <= EXEC_LO;
                        end else begin
                            r_seg_hi <= rom_data;
                            r_first  <= 1'b0;
                            r_state  <= SEG_LO;
                        end
                    end
                    SEG_LO: begin
                        r_seg_lo   <= rom_data;
                        r_rom_addr <= r_rom_addr + 16'd1;
                        r_state    <= SEG_SIZE;
                    end
                    SEG_SIZE: begin
                        r_remain   <= size_decode(rom_data);
                        r_rom_addr <= r_rom_addr + 16'd1;
                        r_state    <= DATA;
                    end
                    DATA: begin
                        r_ram_wdata <= rom_data;
                        r_ram_addr  <= RAM_ADDR_W'({r_seg_hi, r_seg_lo});
                        r_ram_we    <= 1'b1;
                        r_state     <= WRITE;
                    end
                    WRITE: begin
                        if (ram_ready) begin
                            r_ram_we   <= 1'b0;
                            r_remain   <= r_remain - 9'd1;
                            r_seg_lo   <= r_seg_lo + 8'd1;
                            r_rom_addr <= r_rom_addr + 16'd1;
                            r_state    <= (r_remain == 9'd1) ? SEG_HI : DATA;
                        end
                    end
                    // EXEC_LO takes the execution high byte, EXEC_HI the low byte after it.
                    EXEC_LO: begin
                        r_exec_addr[15:8] <= rom_data;
                        r_rom_addr        <= r_rom_addr + 16'd1;
                        r_state           <= EXEC_HI;
                    end
                    EXEC_HI: begin
                        r_exec_addr[7:0] <= rom_data;
                        r_rom_addr       <= r_rom_addr + 16'd1;
                        r_done           <= 1'b1;
                        r_cpu_hold       <= 1'b0;
                        r_state          <= DONE;
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr  = r_rom_addr;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;
    assign exec_addr = r_exec_addr;

endmodule

// File: doc/gigatron_gt1_loader.md
GIGATRON_GT1_LOADER -- requirements
Module: gigatron_gt1_loader

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 32768, meaning the number of valid option-ROM bytes (addresses 0..ROM_DEPTH-1).
REQ-002 SHALL have parameter RAM_ADDR_W, default 16, meaning the Gigatron RAM address width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a load from ROM address 0.
REQ-006 SHALL have port rom_addr, output, 16, the option-ROM byte address.
REQ-007 SHALL have port rom_data, input, 8, the option-ROM byte; combinational and valid in the same cycle as rom_addr.
REQ-008 SHALL have port ram_addr, output, RAM_ADDR_W, the target RAM write address.
REQ-009 SHALL have port ram_wdata, output, 8, the target RAM write data.
REQ-010 SHALL have port ram_we, output, 1, the write request; held until accepted.
REQ-011 SHALL have port ram_ready, input, 1, the write accept; a write completes in a cycle where ram_we and ram_ready are both 1.
REQ-012 SHALL have port cpu_hold, output, 1, which holds the Gigatron CPU while a load is active.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse on successful completion.
REQ-014 SHALL have port error, output, 1, sticky until the next start or reset.
REQ-015 SHALL have port exec_addr, output, 16, the GT1 execution address, valid while done is pulsed and held until the next start.

Function
REQ-016 SHALL parse the GT1 format: segments of hi, lo, size (0 means 256) and size data bytes; the list ends at a hi byte equal to 0 on any segment after the first, followed by the exec hi and exec lo bytes.
REQ-017 SHALL use states IDLE, SEG_HI, SEG_LO, SEG_SIZE, DATA, WRITE, EXEC_HI, EXEC_LO, DONE and ERROR.
REQ-018 SHALL, in IDLE, move to SEG_HI on start with rom_addr=0, clear error and set cpu_hold=1.
REQ-019 SHALL have each header state consume one ROM byte per cycle and advance rom_addr by 1.
REQ-020 SHALL move SEG_HI to EXEC_LO when the byte is 0 and this is not the first segment; otherwise it SHALL move to SEG_LO.
REQ-021 SHALL, in DATA, latch rom_data into ram_wdata and the current segment address into ram_addr, assert ram_we and go to WRITE.
REQ-022 SHALL, in WRITE, hold ram_addr, ram_wdata and ram_we stable until ram_ready; on accept it SHALL decrement the 9-bit remaining count, increment only the low address byte (wrap within the 256-byte page) and increment rom_addr.
REQ-023 SHALL return WRITE to SEG_HI when the remaining count reaches 0, and otherwise to DATA.
REQ-024 SHALL load exec_addr hi in EXEC_LO, load the low byte in the following cycle, then go to DONE.
REQ-025 SHALL, in DONE, pulse done for one cycle, clear cpu_hold and return to IDLE.
REQ-026 SHALL ignore start while not in IDLE or ERROR; start in ERROR restarts the load.
REQ-027 SHALL, with ram_ready tied to 1, load one data byte in 2 cycles.

Reset
REQ-028 SHALL, while reset_n=0 at the clock edge, go to IDLE with rom_addr=0, ram_addr=0, ram_wdata=0, ram_we=0, cpu_hold=0, done=0, error=0 and exec_addr=0.
REQ-029 SHALL abort a load mid-operation on reset, including during WRITE, and drop ram_we in the next cycle.

Configuration
REQ-030 SHALL, with GT1_LOADER_BOUNDS_EN defined, enter ERROR (error=1, cpu_hold=0, ram_we=0) when a byte is required at rom_addr >= ROM_DEPTH.
REQ-031 SHALL, without GT1_LOADER_BOUNDS_EN, wrap rom_addr modulo 65536 and not assert error.

Structure
REQ-032 SHALL place the state enum type and the GT1 field constants (END_HI=0, SIZE_ZERO_MEANS=256) in package gigatron_gt1_pkg.
REQ-033 SHALL contain no sub-module; the ROM stays external and is driven via rom_addr.

Verification
REQ-034 SHALL verify: ROM {0x02,0x00,0x02,0xAA,0xBB,0x00,0x02,0x00}, start, ram_ready=1 -> writes 0x0200=AA and 0x0201=BB; done pulses once; exec_addr=0x0200; cpu_hold falls with done.
REQ-035 SHALL verify: a segment with size byte 0 at 0x0300 -> 256 writes, 0x0300..0x03FF in order.
REQ-036 SHALL verify: a segment at hi=0x05, lo=0xFF, size 2 -> writes to 0x05FF then 0x0500 (page wrap).
REQ-037 SHALL verify: ram_ready held low 5 cycles during the first write -> ram_addr, ram_wdata and ram_we stable throughout; no byte skipped.
REQ-038 SHALL verify: reset_n low during WRITE -> next cycle ram_we=0 and cpu_hold=0; a later start reloads from address 0.
REQ-039 SHALL verify: with GT1_LOADER_BOUNDS_EN, ROM_DEPTH=4 and a truncated image -> error=1 with no done; a start then clears error.
